regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_clear_seq.sv | 59 +++++
 rtl/regfile_param.sv | 120 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parameterised register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 16;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear-sweep sequencer: walks every register index once after reset or a clear request.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A clear request while already sweeping is ignored rather than restarting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    clr_en   = (state_q == CLEAR);
    clr_addr = idx_q;
  end

endmodule

// File: rtl/regfile_param.sv
// Dual-read, single-write register file with registered reads and a clear sweep.
// Define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              read,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  output logic [DATA_W-1:0] value1,
  output logic [DATA_W-1:0] value2,
  output logic              rd_valid,
  input  logic              clear,
  output logic              busy,
  output logic              wr_err
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] value1_q, value1_d;
  logic [DATA_W-1:0] value2_q, value2_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_err_q, wr_err_d;

  logic              addr_is_zero_reg;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1_word, rd2_word;

  regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign addr_is_zero_reg = ZERO_REG_EN && (address == '0);
  assign wr_ok            = write && !busy && !addr_is_zero_reg;

  // Write-first bypass so a same-cycle write is visible on either read port.
  assign rd1_word = (ZERO_REG_EN && (read1 == '0)) ? '0 :
                    (wr_ok && (address == read1)) ? data : mem_q[read1];
  assign rd2_word = (ZERO_REG_EN && (read2 == '0)) ? '0 :
                    (wr_ok && (address == read2)) ? data : mem_q[read2];

  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_addr] = '0;
    end
    if (wr_ok) begin
      mem_d[address] = data;
    end
  end

  always_comb begin
    value1_d   = value1_q;
    value2_d   = value2_q;
    rd_valid_d = 1'b0;
    wr_err_d   = write && busy && !addr_is_zero_reg;
    if (read) begin
      if (busy) begin
        value1_d = '0;
        value2_d = '0;
      end else begin
        value1_d   = rd1_word;
        value2_d   = rd2_word;
        rd_valid_d = 1'b1;
      end
    end
  end

  // Storage is not reset directly; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value1_q   <= '0;
      value2_q   <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      value1_q   <= value1_d;
      value2_q   <= value2_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign value1   = value1_q;
  assign value2   = value2_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;

endmodule
